prod_acc: RTL

PROD_ACC -- requirements
Module: prod_acc

---
 rtl/prod_acc.sv | 129 ++++++++++++
 1 files changed

// File: rtl/prod_acc.sv
// prod_acc: frame accumulator for signed products from an upstream multiplier.
//
// It accepts LEN products per frame through a valid/ready handshake and adds
// each one into a signed ACC_W-bit accumulator. The accumulator saturates
// instead of wrapping. When the frame is complete, the saturated sum and a
// sticky overflow flag are offered downstream through a second valid/ready
// handshake.
//
// Ports:
//   clk       - single clock; all state changes on the rising edge
//   rst       - synchronous active-high reset
//   P         - signed product from the mul stage, bit_A+bit_B bits
//   in_valid  - P is valid this cycle
//   in_ready  - block accepts P this cycle (high only while accumulating)
//   acc_out   - signed saturated sum; shows the running partial sum while
//               accumulating and the final frame sum while out_valid is high
//   ovf       - saturation happened at least once in the current frame
//   out_valid - acc_out/ovf hold a completed frame result
//   out_ready - downstream takes the result
module prod_acc #(
  parameter int bit_A = 5,
  parameter int bit_B = 7,
  parameter int LEN   = 8,
  parameter int ACC_W = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [bit_A+bit_B-1:0] P,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [ACC_W-1:0]       acc_out,
  output logic                   ovf,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int PW = bit_A + bit_B;
  localparam int CW = $clog2(LEN);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_t;

  state_t state, next_state;

  logic [CW-1:0]    cnt;
  logic [ACC_W-1:0] acc;
  logic             ovf_q;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] sat_val;
  logic             clip;
  logic             xfer_in;
  logic             xfer_out;

  assign xfer_in  = in_valid && (state == ACC);
  assign xfer_out = out_ready && (state == OUT);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACC;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: leave ACC on the LEN-th accepted product and
  // return to ACC once downstream takes the result
  always_comb begin
    next_state = state;
    case (state)
      ACC: if (in_valid && (cnt == LAST)) next_state = OUT;
      OUT: if (out_ready) next_state = ACC;
      default: next_state = ACC;
    endcase
  end

  // Handshake outputs depend on state only
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACC: in_ready = 1'b1;
      OUT: out_valid = 1'b1;
      default: in_ready = 1'b1;
    endcase
  end

  // Add one guard bit so that any overflow of the ACC_W-bit range shows up
  // as a disagreement between the two top bits of the sum
  always_comb begin
    sum     = {acc[ACC_W-1], acc} + {{(ACC_W + 1 - PW){P[PW-1]}}, P};
    clip    = 1'b0;
    sat_val = sum[ACC_W-1:0];
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      clip = 1'b1;
      if (sum[ACC_W]) begin
        sat_val = {1'b1, {(ACC_W - 1){1'b0}}};
      end else begin
        sat_val = {1'b0, {(ACC_W - 1){1'b1}}};
      end
    end
  end

  // Datapath: accumulate on accepted products and clear after a result
  // handoff. The counter wraps to 0 on the last product, so it is already
  // clean when the next frame starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else if (xfer_in) begin
      acc   <= sat_val;
      ovf_q <= ovf_q | clip;
      cnt   <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end else if (xfer_out) begin
      acc   <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end
  end

  assign acc_out = acc;
  assign ovf     = ovf_q;

endmodule
